// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and the tick divider helper for switch_debounce_sync
package debounce_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int MIN_STABLE_SAMPLES = 2;
  function automatic int tick_div(input int clk_hz, input int period_us);
    return (clk_hz / 1000000) * period_us;
  endfunction
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser plus tick-sampled history filter for one input line
import debounce_pkg::*;
module debounce_bit #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic flip
);
  logic sync1, sync2;
  logic [STABLE_SAMPLES-1:0] hist, new_hist;
  assign new_hist = {hist[STABLE_SAMPLES-2:0], sync2};
  // A flip needs every sample in the window to disagree with the current level
  assign flip = tick & (level ? ~|new_hist : &new_hist);
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (tick) begin
        hist  <= new_hist;
        level <= level ^ flip;
      end
    end
  end
endmodule

// File: rtl/switch_debounce_sync.sv
// switch_debounce_sync: synchronise and debounce WIDTH raw lines, flag changes via pulse and sticky mask.
// Define DEBOUNCE_IRQ_EN to add a level irq output with irq_ack clear.
import debounce_pkg::*;
module switch_debounce_sync #(
  parameter int CLK_FREQ_IN_HZ   = 25000000,
  parameter int SAMPLE_PERIOD_US = 1000,
  parameter int STABLE_SAMPLES   = 4,
  parameter int WIDTH            = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             clr_changed,
  output logic [WIDTH-1:0] debounced,
  output logic             change_pulse,
  output logic [WIDTH-1:0] changed_mask
`ifdef DEBOUNCE_IRQ_EN
  ,
  input  logic             irq_ack,
  output logic             irq
`endif
);
  localparam int TICK_DIV = tick_div(CLK_FREQ_IN_HZ, SAMPLE_PERIOD_US);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  if (STABLE_SAMPLES < MIN_STABLE_SAMPLES) begin : g_bad_samples
    $error("STABLE_SAMPLES must be at least %0d", MIN_STABLE_SAMPLES);
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("tick divider must be at least 1");
  end
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] flips;
  logic tick;
  assign tick = cnt == LAST;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_bit (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .raw   (raw_in[i]),
      .level (debounced[i]),
      .flip  (flips[i])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      change_pulse <= 1'b0;
      changed_mask <= '0;
    end else begin
      cnt          <= tick ? '0 : cnt + CW'(1);
      change_pulse <= |flips;
      changed_mask <= (clr_changed ? '0 : changed_mask) | flips;
    end
  end
`ifdef DEBOUNCE_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else irq <= |flips ? 1'b1 : irq_ack ? 1'b0 : irq;
  end
`endif
endmodule

// File: tb/tb_switch_debounce_sync.sv
// tb_switch_debounce_sync: scoreboard bench for switch_debounce_sync with TICK_DIV=4, STABLE_SAMPLES=4
module tb_switch_debounce_sync;
  typedef struct packed {
    logic [7:0] deb;
    logic [7:0] mask;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] raw_in = 8'h00;
  logic clr_changed = 1'b0;
  logic [7:0] debounced, changed_mask;
  logic change_pulse;
`ifdef DEBOUNCE_IRQ_EN
  logic irq_ack = 1'b0;
  logic irq;
`endif
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  switch_debounce_sync #(
    .CLK_FREQ_IN_HZ   (1000000),
    .SAMPLE_PERIOD_US (4),
    .STABLE_SAMPLES   (4),
    .WIDTH            (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_in       (raw_in),
    .clr_changed  (clr_changed),
    .debounced    (debounced),
    .change_pulse (change_pulse),
    .changed_mask (changed_mask)
`ifdef DEBOUNCE_IRQ_EN
    ,
    .irq_ack      (irq_ack),
    .irq          (irq)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (change_pulse) begin
      pulses++;
      if (sb.size() == 0) chk("spurious_pulse", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_deb", {24'h0, debounced}, {24'h0, e.deb});
        chk("sb_mask", {24'h0, changed_mask}, {24'h0, e.mask});
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_pulse(input string tag, input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!change_pulse && n < max_cyc);
    if (!change_pulse) chk({tag, "_timeout"}, 1, 0);
  endtask
  initial begin
    int n;
    int p0;
    idle(3);
    chk("rst_deb", {24'h0, debounced}, 0);
    chk("rst_pulse", {31'h0, change_pulse}, 0);
    chk("rst_mask", {24'h0, changed_mask}, 0);
    reset = 1'b0;
    idle(100);
    chk("quiet_deb", {24'h0, debounced}, 0);
    chk("quiet_mask", {24'h0, changed_mask}, 0);
    chk("quiet_pulses", pulses, 0);
    sb.push_back('{deb: 8'h05, mask: 8'h05});
    raw_in = 8'h05;
    wait_pulse("rise05", 40, n);
    chk("rise05_latency", {31'h0, n >= 12 && n <= 18}, 1);
    idle(1);
    chk("rise05_one_cycle", {31'h0, change_pulse}, 0);
    chk("rise05_deb", {24'h0, debounced}, 8'h05);
    chk("rise05_mask", {24'h0, changed_mask}, 8'h05);
    p0 = pulses;
    raw_in = 8'h0D;
    idle(6);
    raw_in = 8'h05;
    idle(40);
    chk("glitch_deb", {24'h0, debounced}, 8'h05);
    chk("glitch_pulses", pulses, p0);
    sb.push_back('{deb: 8'h85, mask: 8'h80});
    raw_in = 8'h85;
    clr_changed = 1'b1;
    wait_pulse("clr_flip", 40, n);
    clr_changed = 1'b0;
    idle(1);
    chk("clr_flip_keep", {24'h0, changed_mask}, 8'h80);
    clr_changed = 1'b1;
    idle(1);
    clr_changed = 1'b0;
    chk("lone_clear", {24'h0, changed_mask}, 8'h00);
    raw_in = 8'hFF;
    idle(5);
    reset = 1'b1;
    idle(3);
    chk("midrst_deb", {24'h0, debounced}, 0);
    chk("midrst_mask", {24'h0, changed_mask}, 0);
    sb.push_back('{deb: 8'hFF, mask: 8'hFF});
    p0 = pulses;
    reset = 1'b0;
    wait_pulse("after_rst", 40, n);
    chk("after_rst_latency", {31'h0, n >= 16 && n <= 20}, 1);
    idle(30);
    chk("after_rst_single", pulses, p0 + 1);
    clr_changed = 1'b1;
    idle(1);
    clr_changed = 1'b0;
    sb.push_back('{deb: 8'h0F, mask: 8'hF0});
    p0 = pulses;
    raw_in = 8'h0F;
    wait_pulse("multi", 40, n);
    idle(30);
    chk("multi_single", pulses, p0 + 1);
    chk("multi_mask", {24'h0, changed_mask}, 8'hF0);
`ifdef DEBOUNCE_IRQ_EN
    irq_ack = 1'b1;
    idle(1);
    irq_ack = 1'b0;
    chk("irq_acked", {31'h0, irq}, 0);
    sb.push_back('{deb: 8'h0E, mask: 8'hF1});
    raw_in = 8'h0E;
    wait_pulse("irq_set", 40, n);
    chk("irq_set", {31'h0, irq}, 1);
    sb.push_back('{deb: 8'h0C, mask: 8'hF3});
    raw_in = 8'h0C;
    irq_ack = 1'b1;
    wait_pulse("irq_race", 40, n);
    irq_ack = 1'b0;
    chk("irq_set_wins", {31'h0, irq}, 1);
    idle(1);
    irq_ack = 1'b1;
    idle(1);
    irq_ack = 1'b0;
    chk("irq_lone_ack", {31'h0, irq}, 0);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
